// File: rtl/ser_adder.sv
// ser_adder: bit-serial adder/subtractor, one full-adder slice, LSB first, W+1 cycle operation
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin an operation (accepted in IDLE or DONE, ignored in RUN)
//   a, b, ci, sub   operands, carry-in, mode (0: a+b+ci, 1: a-b); sampled on accepted start
//   busy            high while result bits are being computed
//   done            one-cycle pulse, s/co/ovf final
//   s, co, ovf      result, carry-out (no-borrow in sub mode), signed overflow
module ser_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       r_state;
    logic [W-1:0] r_a, r_b, r_s;
    logic [5:0]   r_cnt;
    logic         r_c, r_busy, r_done, r_ovf;
    logic         w_sbit, w_cout, w_last;
    assign w_sbit = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cout = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_last = r_cnt == 6'(W - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // subtraction is a + ~b + 1: invert b and preload carry with 1
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub | ci;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_c   <= w_cout;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    // new bit enters at the MSB; after W shifts bit 0 sits at the LSB
                    r_s   <= W'({w_sbit, r_s} >> 1);
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        // r_c here is the carry into the MSB slice
                        r_ovf   <= r_c ^ w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_c;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_ser_adder.sv
// tb_ser_adder: table-driven, directed and randomized checks of ser_adder at W=1, 4 and 8
module tb_ser_adder;
    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st1 = 0, ci1 = 0, sb1 = 0, bz1, dn1, co1, ov1;
    logic [0:0] a1 = 0, b1 = 0, s1;
    logic       st4 = 0, ci4 = 0, sb4 = 0, bz4, dn4, co4, ov4;
    logic [3:0] a4 = 0, b4 = 0, s4;
    logic       st8 = 0, ci8 = 0, sb8 = 0, bz8, dn8, co8, ov8;
    logic [7:0] a8 = 0, b8 = 0, s8;

    ser_adder #(.W(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .ci(ci1), .sub(sb1),
                           .busy(bz1), .done(dn1), .s(s1), .co(co1), .ovf(ov1));
    ser_adder #(.W(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .ci(ci4), .sub(sb4),
                           .busy(bz4), .done(dn4), .s(s4), .co(co4), .ovf(ov4));
    ser_adder #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .ci(ci8), .sub(sb8),
                           .busy(bz8), .done(dn8), .s(s8), .co(co8), .ovf(ov8));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_in(input int w, input logic st, input logic [31:0] ia, input logic [31:0] ib,
                          input logic ici, input logic isub);
        case (w)
            1: begin st1 = st; a1 = ia[0];   b1 = ib[0];   ci1 = ici; sb1 = isub; end
            4: begin st4 = st; a4 = ia[3:0]; b4 = ib[3:0]; ci4 = ici; sb4 = isub; end
            default: begin st8 = st; a8 = ia[7:0]; b8 = ib[7:0]; ci8 = ici; sb8 = isub; end
        endcase
    endtask

    task automatic get_out(input int w, output logic bz, output logic dn, output logic [31:0] os,
                           output logic oco, output logic oovf);
        case (w)
            1: begin bz = bz1; dn = dn1; os = 32'(s1); oco = co1; oovf = ov1; end
            4: begin bz = bz4; dn = dn4; os = 32'(s4); oco = co4; oovf = ov4; end
            default: begin bz = bz8; dn = dn8; os = 32'(s8); oco = co8; oovf = ov8; end
        endcase
    endtask

    // reference: unsigned arithmetic for s/co, signed range test for ovf
    task automatic model(input int w, input logic [31:0] ia, input logic [31:0] ib, input logic ici,
                         input logic isub, output logic [31:0] os, output logic oco, output logic oovf);
        longint m, half, ua, ub, sa, sb, u, r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(ia) & m;
        ub   = longint'(ib) & m;
        sa   = ua >= half ? ua - (m + 1) : ua;
        sb   = ub >= half ? ub - (m + 1) : ub;
        if (isub) begin
            u   = ua - ub;
            oco = ua >= ub;
            r   = sa - sb;
        end else begin
            u   = ua + ub + longint'(ici);
            oco = u > m;
            r   = sa + sb + longint'(ici);
        end
        os   = 32'(u & m);
        oovf = (r >= half) || (r < -half);
    endtask

    // one full operation; lat = negedges after the accepting edge until done is seen (-1 on timeout)
    task automatic op(input int w, input logic [31:0] ia, input logic [31:0] ib, input logic ici,
                      input logic isub, output logic [31:0] os, output logic oco, output logic oovf,
                      output int lat, output logic pulse_ok);
        logic bz, dn, c, o;
        logic [31:0] ss;
        set_in(w, 1'b1, ia, ib, ici, isub);
        @(negedge clk);
        set_in(w, 1'b0, ia, ib, ici, isub);
        lat = -1;
        pulse_ok = 1'b1;
        ss = '0; c = 0; o = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            get_out(w, bz, dn, ss, c, o);
            if (dn) begin
                lat = k;
                pulse_ok &= !bz;
                break;
            end
            pulse_ok &= bz;
        end
        os = ss; oco = c; oovf = o;
        @(negedge clk);
        get_out(w, bz, dn, ss, c, o);
        pulse_ok &= !dn && !bz;
    endtask

    task automatic wait_done(input int w, inout int t, output logic ok);
        logic bz, dn, c, o;
        logic [31:0] ss;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            t++;
            get_out(w, bz, dn, ss, c, o);
            if (dn) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string nm, input int w, input logic [31:0] ia, input logic [31:0] ib,
                                 input logic ici, input logic isub, input logic [31:0] es,
                                 input logic eco, input logic eovf);
        logic [31:0] gs;
        logic gco, govf, pok;
        int lat;
        op(w, ia, ib, ici, isub, gs, gco, govf, lat, pok);
        chk({nm, " s"}, 64'(gs), 64'(es));
        chk({nm, " co/ovf"}, {62'b0, gco, govf}, {62'b0, eco, eovf});
        chk({nm, " latency"}, 64'(lat), 64'(w));
        chk({nm, " busy/done pulse"}, 64'(pok), 64'd1);
    endtask

    initial begin
        vec_t tv[14];
        logic bz, dn, c, o, ok;
        logic [31:0] ss, es, ra, rb;
        logic eco, eovf, rci, rsub;
        int t, t1, ndone, w;

        tv[0]  = '{1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        tv[1]  = '{1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b1};
        tv[2]  = '{1, 32'h0, 32'h1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0};
        tv[3]  = '{1, 32'h0, 32'h1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
        tv[4]  = '{1, 32'h1, 32'h0, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0};
        tv[5]  = '{1, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
        tv[6]  = '{1, 32'h1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[7]  = '{1, 32'h1, 32'h1, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0};
        tv[8]  = '{4, 32'h7, 32'h1, 1'b0, 1'b0, 32'h8, 1'b0, 1'b1};
        tv[9]  = '{4, 32'h3, 32'h5, 1'b0, 1'b1, 32'hE, 1'b0, 1'b0};
        tv[10] = '{4, 32'h8, 32'h1, 1'b0, 1'b1, 32'h7, 1'b1, 1'b1};
        tv[11] = '{8, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1};
        tv[12] = '{8, 32'h00, 32'h01, 1'b1, 1'b1, 32'hFF, 1'b0, 1'b0};
        tv[13] = '{8, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        get_out(1, bz, dn, ss, c, o);
        chk("reset W1", {29'b0, bz, dn, c, o, ss}, 64'd0);
        get_out(4, bz, dn, ss, c, o);
        chk("reset W4", {29'b0, bz, dn, c, o, ss}, 64'd0);
        get_out(8, bz, dn, ss, c, o);
        chk("reset W8", {29'b0, bz, dn, c, o, ss}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_and_check($sformatf("table[%0d]", i), tv[i].w, tv[i].a, tv[i].b, tv[i].ci, tv[i].sub,
                          tv[i].s, tv[i].co, tv[i].ovf);

        // start pulse at RUN cycle 3 must not disturb the running operation
        set_in(8, 1'b1, 32'hFF, 32'h01, 1'b1, 1'b0);
        @(negedge clk);
        t = 0;
        set_in(8, 1'b0, 32'hFF, 32'h01, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        t = 2;
        set_in(8, 1'b1, 32'h55, 32'h0F, 1'b0, 1'b1);
        @(negedge clk);
        t = 3;
        set_in(8, 1'b0, 32'h55, 32'h0F, 1'b0, 1'b1);
        wait_done(8, t, ok);
        get_out(8, bz, dn, ss, c, o);
        chk("midrun-start done seen", 64'(ok), 64'd1);
        chk("midrun-start latency", 64'(t), 64'd8);
        chk("midrun-start result", {30'b0, c, o, ss}, {30'b0, 1'b1, 1'b0, 32'h01});
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn8) ndone++;
        end
        chk("midrun-start no extra done", 64'(ndone), 64'd0);

        // back-to-back: start held high through DONE
        set_in(8, 1'b1, 32'h12, 32'h34, 1'b0, 1'b0);
        @(negedge clk);
        t = 0;
        wait_done(8, t, ok);
        t1 = t;
        get_out(8, bz, dn, ss, c, o);
        chk("b2b first result", {30'b0, c, o, ss}, {30'b0, 1'b0, 1'b0, 32'h46});
        chk("b2b first latency", 64'(t1), 64'd8);
        set_in(8, 1'b1, 32'h50, 32'h60, 1'b0, 1'b1);
        @(negedge clk);
        t++;
        set_in(8, 1'b0, 32'h50, 32'h60, 1'b0, 1'b1);
        chk("b2b done single cycle, busy again", {62'b0, dn8, bz8}, 64'd1);
        wait_done(8, t, ok);
        get_out(8, bz, dn, ss, c, o);
        chk("b2b done spacing", 64'(t - t1), 64'd9);
        chk("b2b second result", {30'b0, c, o, ss}, {30'b0, 1'b0, 1'b0, 32'hF0});
        @(negedge clk);

        // reset during RUN aborts with no done pulse
        set_in(8, 1'b1, 32'hAB, 32'hCD, 1'b0, 1'b0);
        @(negedge clk);
        set_in(8, 1'b0, 32'hAB, 32'hCD, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        get_out(8, bz, dn, ss, c, o);
        chk("midrun reset outputs", {29'b0, bz, dn, c, o, ss}, 64'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn8 || bz8) ndone++;
        end
        chk("midrun reset no done", 64'(ndone), 64'd0);
        run_and_check("after reset 10+20", 8, 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0);

        // reset wins over start on the same edge
        rst_n = 1'b0;
        set_in(8, 1'b1, 32'h01, 32'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset priority over start", {62'b0, bz8, dn8}, 64'd0);
        rst_n = 1'b1;
        set_in(8, 1'b0, 32'h01, 32'h02, 1'b0, 1'b0);
        @(negedge clk);

        // randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: w = 1;
                1, 2: w = 4;
                default: w = 8;
            endcase
            ra   = $urandom;
            rb   = $urandom;
            rci  = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            model(w, ra, rb, rci, rsub, es, eco, eovf);
            run_and_check($sformatf("rand[%0d] w=%0d a=%0h b=%0h ci=%0b sub=%0b", i, w, ra, rb, rci, rsub),
                          w, ra, rb, rci, rsub, es, eco, eovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ser_adder.md
SER_ADDER -- requirements
Module: ser_adder

Interface
REQ-001 SHALL have parameter W, default 8, operand/result width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on rising edge.
REQ-005 SHALL have port a  input  W  operand A; sampled only on an accepted start.
REQ-006 SHALL have port b  input  W  operand B; sampled only on an accepted start.
REQ-007 SHALL have port ci  input  1  carry-in for add mode; sampled with the operands; ignored when sub=1.
REQ-008 SHALL have port sub  input  1  mode, sampled with the operands: 0 = A+B+ci, 1 = A-B.
REQ-009 SHALL have port busy  output  1  high while bits are being computed.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port s  output  W  result sum/difference.
REQ-012 SHALL have port co  output  1  carry-out; in sub mode, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  signed two's-complement overflow of the result.

Function
REQ-014 SHALL compute bit-serially, LSB first, with exactly one 1-bit full-adder slice and one carry flip-flop; no W-bit parallel adder.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL accept start in IDLE: latch a, latch b (inverted when sub=1), load carry with ci (sub=0) or 1 (sub=1), clear bit counter, go to RUN.
REQ-017 SHALL, in RUN, compute one result bit per cycle on each edge: s_bit = a0^b0^c, c <= majority(a0,b0,c); shift operand registers right; shift s_bit into the result MSB.
REQ-018 SHALL leave RUN for DONE after exactly W RUN edges; busy = 1 in RUN only.
REQ-019 SHALL assert done = 1 for exactly one cycle in DONE, with s, co, ovf stable and final.
REQ-020 SHALL latency: start accepted at edge E0; done high in the cycle following edge EW; for W=8, done is high 8 cycles after the start edge.
REQ-021 SHALL go DONE -> IDLE on the next edge, unless start=1, in which case the FSM goes DONE -> RUN, accepts the new operands, and deasserts done.
REQ-022 SHALL ignore start while in RUN; the operation in progress and its operands are unaffected.
REQ-023 SHALL set co = final carry register value.
REQ-024 SHALL set ovf = carry into bit W-1 XOR carry out of bit W-1; the carry into bit W-1 is captured in the cycle that computes bit W-1.
REQ-025 SHALL hold s, co and ovf from DONE through IDLE until the next accepted start; during RUN they are don't-care for consumers, who must qualify them with done.
REQ-026 SHALL, for W=1, behave as a registered single full adder: s = a^b^ci, co = majority(a,b,ci), done two edges after start.

Reset
REQ-027 SHALL, on any rising edge with rst_n=0, force IDLE and clear busy, done, s, co, ovf, carry, counter and operand registers to 0.
REQ-028 SHALL, when reset is applied mid-RUN, abort the operation with no done pulse; the next start after release begins a fresh operation.
REQ-029 SHALL give reset priority over start on the same edge.

Verification
REQ-030 SHALL verify W=1, all 8 (a,b,ci) combinations: s and co match the full-adder truth table (e.g. 1,1,1 -> s=1, co=1).
REQ-031 SHALL verify W=4 add, a=4'h7, b=4'h1, ci=0: s=4'h8, co=0, ovf=1, with done high 4 cycles after the start edge.
REQ-032 SHALL verify W=4 sub, a=4'h3, b=4'h5: s=4'hE, co=0, ovf=0; and a=4'h8, b=4'h1: s=4'h7, co=1, ovf=1.
REQ-033 SHALL verify W=8 add, a=8'hFF, b=8'h01, ci=1: s=8'h01, co=1, ovf=0; a start pulse at RUN cycle 3 with other operands does not change this result.
REQ-034 SHALL verify back-to-back operation, W=8: start held high through DONE accepts a second operation immediately; two done pulses occur 9 cycles apart.
REQ-035 SHALL verify reset mid-op: rst_n=0 at RUN cycle 4, then released: all outputs 0, no done pulse; next start, a=8'h10, b=8'h20, gives s=8'h30.
